// File: rtl/multicycle_pkg.sv
// multicycle_pkg: state, opcode and datapath select encodings
// shared by the RV32I multi-cycle controller.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_ALU = 2'b01;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_perf.sv
// multicycle_perf: free-running cycle and retired-instruction
// counters, wrapping modulo 2^CNT_W.
module multicycle_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_retire,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret_cnt
);

  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (i_retire)
        r_instret <= r_instret + 1'b1;
    end
  end

  assign o_cycle_cnt   = r_cycle;
  assign o_instret_cnt = r_instret;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the
// multi-cycle RV32I datapath. MULTICYCLE_PERF_EN adds perf counters.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Gated by rst so nothing, not even the FETCH request, leaks during reset
  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    illegal   = 1'b0;
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SEQ;
            w_next   = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
          if (op_legal(opcode)) begin
            w_next = S_EXEC;
          end else begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        end
        S_EXEC: begin
          w_next = S_WB;
          case (opcode)
            OP_R: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_RS2;
              alu_op    = ALU_R;
            end
            OP_I: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              alu_op    = ALU_I;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              w_next    = S_MEM;
            end
            OP_BRANCH: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_RS2;
              alu_op    = ALU_BR;
              pc_write  = branch_taken;
              pc_src    = PC_ALU;
              w_next    = S_FETCH;
            end
            OP_JAL: begin
              alu_src_b = SRCB_IMM;
              reg_write = 1'b1;
              wb_sel    = WB_PC;
            end
            OP_JALR: begin
              alu_src_a = SRCA_RS1;
              alu_src_b = SRCB_IMM;
              reg_write = 1'b1;
              wb_sel    = WB_PC;
            end
            OP_LUI: begin
              alu_src_a = SRCA_ZERO;
              alu_src_b = SRCB_IMM;
            end
            OP_AUIPC: begin
              alu_src_b = SRCB_IMM;
            end
            default: w_next = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode == OP_STORE);
          if (mem_ready)
            w_next = (opcode == OP_LOAD) ? S_WB : S_FETCH;
        end
        S_WB: begin
          w_next = S_FETCH;
          if (opcode == OP_JAL || opcode == OP_JALR) begin
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end else begin
            reg_write = 1'b1;
            wb_sel    = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
          end
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic w_retire;

  assign w_retire = (r_state == S_WB)
                 || (r_state == S_EXEC && opcode == OP_BRANCH)
                 || (r_state == S_MEM && mem_ready
                     && opcode == OP_STORE);

  multicycle_perf #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_retire      (w_retire),
    .o_cycle_cnt   (cycle_cnt),
    .o_instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream, per-instruction
// summaries checked against a latency/event model through a queue.
module tb_multicycle_control;

  localparam int CNT_W = 4;
`ifdef MULTICYCLE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_LD  = 7'b0000011;
  localparam logic [6:0] T_ST  = 7'b0100011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_JR  = 7'b1100111;
  localparam logic [6:0] T_LUI = 7'b0110111;
  localparam logic [6:0] T_AUI = 7'b0010111;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic branch_taken, mem_ready;
  logic mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic reg_write, illegal;
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .illegal(illegal), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  typedef struct {
    int lat;
    int nir, ir_cyc, npw0;
    int nrw, rw_cyc, rw_sel;
    int npw1, pw1_cyc;
    int nill, ill_cyc;
    int nmem, nwe;
    int dec_sig, ex_sig;
    int instret;
  } rec_t;

  rec_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int retired = 0;
  int ncyc;

  always @(posedge clk or posedge rst)
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_legal(logic [6:0] op);
    return op inside {T_R, T_I, T_LD, T_ST, T_BR,
                      T_JAL, T_JR, T_LUI, T_AUI};
  endfunction

  // {alu_src_a, alu_src_b, alu_op} expected in EXEC per instruction class
  function automatic int ex_sig_of(logic [6:0] op);
    case (op)
      T_R:         return 6'b01_00_10;
      T_I:         return 6'b01_01_11;
      T_LD, T_ST:  return 6'b01_01_00;
      T_BR:        return 6'b01_00_01;
      T_JAL:       return 6'b00_01_00;
      T_JR:        return 6'b01_01_00;
      T_LUI:       return 6'b10_01_00;
      T_AUI:       return 6'b00_01_00;
      default:     return 0;
    endcase
  endfunction

  function automatic rec_t model(logic [6:0] op, bit bt,
                                 int fw, int mw, int ret);
    rec_t r = '{default: 0};
    int e = fw + 3;
    r.nir = 1; r.ir_cyc = fw + 1; r.npw0 = 1;
    r.dec_sig = 6'b00_01_00;
    r.instret = PERF ? ret % 16 : 0;
    if (!is_legal(op)) begin
      r.lat = fw + 2; r.nill = 1; r.ill_cyc = fw + 2;
      return r;
    end
    r.ex_sig = ex_sig_of(op);
    case (op)
      T_LD: begin
        r.lat = fw + mw + 5; r.nmem = mw + 1;
        r.nrw = 1; r.rw_cyc = r.lat; r.rw_sel = 1;
      end
      T_ST: begin
        r.lat = fw + mw + 4; r.nmem = mw + 1; r.nwe = mw + 1;
      end
      T_BR: begin
        r.lat = e;
        if (bt) begin r.npw1 = 1; r.pw1_cyc = e; end
      end
      T_JAL, T_JR: begin
        r.lat = fw + 4; r.nrw = 1; r.rw_cyc = e; r.rw_sel = 2;
        r.npw1 = 1; r.pw1_cyc = fw + 4;
      end
      default: begin
        r.lat = fw + 4; r.nrw = 1; r.rw_cyc = fw + 4;
      end
    endcase
    return r;
  endfunction

  rec_t cur;
  bit in_rec = 1'b0;
  bit prev_fetch = 1'b0;
  bit m_fetch;
  int cyc;

  task automatic close_rec();
    rec_t e;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("latency", cur.lat, e.lat);
    chk("ir_write_cnt", cur.nir, e.nir);
    chk("ir_write_cyc", cur.ir_cyc, e.ir_cyc);
    chk("pc_write_seq_cnt", cur.npw0, e.npw0);
    chk("reg_write_cnt", cur.nrw, e.nrw);
    chk("reg_write_cyc", cur.rw_cyc, e.rw_cyc);
    chk("wb_sel", cur.rw_sel, e.rw_sel);
    chk("pc_write_alu_cnt", cur.npw1, e.npw1);
    chk("pc_write_alu_cyc", cur.pw1_cyc, e.pw1_cyc);
    chk("illegal_cnt", cur.nill, e.nill);
    chk("illegal_cyc", cur.ill_cyc, e.ill_cyc);
    chk("mem_data_cycles", cur.nmem, e.nmem);
    chk("mem_we_cycles", cur.nwe, e.nwe);
    chk("decode_sel", cur.dec_sig, e.dec_sig);
    chk("exec_sel", cur.ex_sig, e.ex_sig);
    chk("instret_cnt", int'(instret_cnt), e.instret);
    chk("cycle_cnt", int'(cycle_cnt), PERF ? ncyc % 16 : 0);
  endtask

  // Monitor: one record per instruction, opened at each new fetch
  always @(negedge clk) begin
    if (rst) begin
      in_rec = 1'b0;
      prev_fetch = 1'b0;
    end else begin
      m_fetch = mem_req && !iord;
      if (m_fetch && !prev_fetch) begin
        if (in_rec) close_rec();
        cur = '{default: 0};
        in_rec = 1'b1;
        cyc = 0;
      end
      if (in_rec) begin
        cyc++;
        cur.lat = cyc;
        if (ir_write) begin cur.nir++; cur.ir_cyc = cyc; end
        if (pc_write && pc_src == 2'b00) cur.npw0++;
        if (pc_write && pc_src == 2'b01) begin
          cur.npw1++; cur.pw1_cyc = cyc;
        end
        if (reg_write) begin
          cur.nrw++; cur.rw_cyc = cyc; cur.rw_sel = int'(wb_sel);
        end
        if (illegal) begin cur.nill++; cur.ill_cyc = cyc; end
        if (mem_req && iord) cur.nmem++;
        if (mem_we) cur.nwe++;
        if (cur.nir > 0 && cyc == cur.ir_cyc + 1)
          cur.dec_sig = int'({alu_src_a, alu_src_b, alu_op});
        if (cur.nir > 0 && cyc == cur.ir_cyc + 2)
          cur.ex_sig = int'({alu_src_a, alu_src_b, alu_op});
      end
      prev_fetch = m_fetch;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(logic [6:0] op, bit bt, int fw, int mw);
    int n = 0;
    int mc = 0;
    if (is_legal(op)) retired++;
    exp_q.push_back(model(op, bt, fw, mw, retired));
    opcode = op;
    branch_taken = bt;
    for (int k = 0; k < fw; k++) begin
      mem_ready = 1'b0;
      tick();
    end
    mem_ready = 1'b1;
    tick();
    while (!(mem_req && !iord) && n < 40) begin
      if (mem_req && iord) begin
        if (mc < mw) begin mem_ready = 1'b0; mc++; end
        else mem_ready = 1'b1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    chk("next_fetch_within_bound", int'(n < 40), 1);
  endtask

  logic [6:0] legal_ops [9];
  logic [6:0] rop;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    legal_ops = '{T_R, T_I, T_LD, T_ST, T_BR,
                  T_JAL, T_JR, T_LUI, T_AUI};
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = T_R;
    branch_taken = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        int'({mem_req, mem_we, iord, ir_write, pc_write, pc_src,
              alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
              illegal, cycle_cnt, instret_cnt}), 0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("mem_req_after_reset", int'({mem_req, iord, mem_we}), 3'b100);

    run(T_R, 1'b0, 0, 0);
    run(T_LD, 1'b0, 3, 2);
    run(T_BR, 1'b0, 0, 0);
    run(T_BR, 1'b1, 0, 0);
    run(T_JR, 1'b0, 0, 0);
    run(7'b1111111, 1'b0, 0, 0);
    run(T_ST, 1'b0, 1, 1);
    run(T_JAL, 1'b1, 0, 0);

    for (int i = 0; i < 70; i++) begin
      if ($urandom_range(0, 10) < 9) begin
        rop = legal_ops[$urandom_range(0, 8)];
      end else begin
        rop = 7'($urandom);
        while (is_legal(rop)) rop = 7'($urandom);
      end
      run(rop, 1'($urandom_range(0, 1)),
          $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Store abandoned by reset while waiting in MEM
    opcode = T_ST;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("store_waiting", int'({mem_req, iord, mem_we}), 3'b111);
    rst = 1'b1;
    #1;
    chk("reset_drops_access",
        int'({mem_req, mem_we, ir_write, pc_write, reg_write}), 0);
    retired = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("fetch_after_reset", int'({mem_req, iord, mem_we}), 3'b100);

    run(T_LUI, 1'b0, 0, 0);
    run(T_AUI, 1'b0, 2, 0);
    run(T_LD, 1'b0, 0, 0);
    run(T_I, 1'b0, 1, 0);

    mem_ready = 1'b0;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
